// File: rtl/snake_dir_input_pkg.sv
// snake_pkg: direction encoding, button indices and the press-to-direction helpers for snake_dir_input.
package snake_pkg;
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_RIGHT = 3;
  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(~d);
  endfunction
  // Simultaneous presses resolve right > left > down > up.
  function automatic dir_t btn_to_dir(input logic [3:0] b);
    return b[BTN_RIGHT] ? DIR_RIGHT : b[BTN_LEFT] ? DIR_LEFT : b[BTN_DOWN] ? DIR_DOWN : DIR_UP;
  endfunction
endpackage

// File: rtl/snake_dir_input_btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stable-count debounce for one button bit.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  logic s1, s2;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/snake_dir_input.sv
// snake_dir_input: debounced buttons to a committed snake direction; SNAKE_DIR_QUEUE_EN selects a 2-entry turn FIFO.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       move_tick,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       pending_valid,
  output logic [3:0] btn_level
);
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
        .clk(clk), .rst_n(rst_n), .raw(btn_raw[i]), .level(btn_level[i])
      );
    end
  endgenerate
  logic [3:0] level_q, press;
  logic press_any, commit;
  dir_t cur, pd, head;
  assign press = btn_level & ~level_q;
  assign press_any = |press;
  assign pd = btn_to_dir(press);
  assign dir = cur;
  // The tick only ever sees the entry held before this cycle's press.
  assign commit = move_tick && pending_valid && head != cur && head != dir_opposite(cur);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      cur <= DIR_RIGHT;
      dir_changed <= 1'b0;
    end else begin
      level_q <= btn_level;
      dir_changed <= commit;
      if (commit) cur <= head;
    end
  end
`ifdef SNAKE_DIR_QUEUE_EN
  dir_t q [2];
  dir_t n_q [2];
  logic [1:0] cnt, n_cnt;
  assign head = q[0];
  assign pending_valid = cnt != 2'd0;
  always_comb begin
    n_q = q;
    n_cnt = cnt;
    if (move_tick && pending_valid) begin
      n_q[0] = q[1];
      n_cnt = cnt - 2'd1;
    end
    if (press_any) begin
      if (n_cnt == 2'd2) n_q[1] = pd;
      else begin
        n_q[n_cnt[0]] = pd;
        n_cnt = n_cnt + 2'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q[0] <= DIR_LEFT;
      q[1] <= DIR_LEFT;
      cnt <= 2'd0;
    end else begin
      q <= n_q;
      cnt <= n_cnt;
    end
  end
`else
  dir_t pend;
  logic pv;
  assign head = pend;
  assign pending_valid = pv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= DIR_LEFT;
      pv <= 1'b0;
    end else if (press_any) begin
      pend <= pd;
      pv <= 1'b1;
    end else if (move_tick) pv <= 1'b0;
  end
`endif
endmodule
